// File: rtl/ddu_run_ctrl.sv
// Debug run controller: single-clock CPU enable sequencing (run / cycle step /
// instruction step / PC breakpoint), button debounce and debug read-address control.
module ddu_run_ctrl #(
    parameter int unsigned DEB_CYCLES   = 10,
    parameter int unsigned REPEAT_DELAY = 250,
    parameter int unsigned REPEAT_RATE  = 50,
    parameter logic [3:0]  FETCH_STATE  = 4'd0
) (
    input  logic        clk_500,
    input  logic        rst_n,
    input  logic        cont,
    input  logic        step,
    input  logic        instr_mode,
    input  logic        inc,
    input  logic        dec,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc_addr,
    input  logic [3:0]  state,
    output logic        cpu_en,
    output logic [7:0]  ddu_raddr,
    output logic        halted,
    output logic        bp_hit
);

    localparam logic [1:0] HALT     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] STEP_CYC = 2'd2;
    localparam logic [1:0] STEP_INS = 2'd3;

    localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1) + 1;
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1) + 1;

    // Synchronizer bit order: {instr_mode, dec, inc, step, cont}
    logic [4:0] sync_a;
    logic [4:0] sync_b;

    always_ff @(posedge clk_500 or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {instr_mode, dec, inc, step, cont};
            sync_b <= sync_a;
        end
    end

    logic       s_cont;
    logic       s_mode;
    logic [2:0] deb_in;

    assign s_cont = sync_b[0];
    assign s_mode = sync_b[4];
    assign deb_in = sync_b[3:1];

    // Debounce bit order: {dec, inc, step}
    logic [2:0]       deb;
    logic [2:0]       deb_d;
    logic [DEB_W-1:0] deb_cnt [3];

    always_ff @(posedge clk_500 or negedge rst_n) begin
        if (!rst_n) begin
            deb   <= '0;
            deb_d <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            deb_d <= deb;
            for (int unsigned i = 0; i < 3; i++) begin
                if (deb_in[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                        deb[i]     <= deb_in[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    logic step_rise;
    logic inc_deb;
    logic dec_deb;
    logic inc_rise;
    logic dec_rise;

    assign step_rise = deb[0] & ~deb_d[0];
    assign inc_deb   = deb[1];
    assign dec_deb   = deb[2];
    assign inc_rise  = deb[1] & ~deb_d[1];
    assign dec_rise  = deb[2] & ~deb_d[2];

    // The cont edge detector is only trusted once both it and the synchronizer
    // hold real samples, so a switch left on through reset does not start a run.
    logic [1:0] prime_cnt;
    logic       cont_d;
    logic       cont_rise;

    always_ff @(posedge clk_500 or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt <= '0;
            cont_d    <= 1'b0;
        end else begin
            cont_d <= s_cont;
            if (prime_cnt != 2'd3) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
        end
    end

    assign cont_rise = (prime_cnt == 2'd3) & s_cont & ~cont_d;

    logic [1:0] fsm;
    logic [1:0] fsm_nx;
    logic       bp_armed;
    logic       at_fetch;
    logic       bp_cond;
    logic       ins_done;
    logic       hit;

    assign at_fetch = (state == FETCH_STATE);
    assign bp_cond  = bp_en & bp_armed & (pc_addr == bp_addr) & at_fetch;
    assign ins_done = (fsm == STEP_INS) & bp_armed & at_fetch;

    always_comb begin
        fsm_nx = fsm;
        hit    = 1'b0;
        case (fsm)
            HALT: begin
                if (cont_rise) begin
                    fsm_nx = RUN;
                end else if (step_rise) begin
                    fsm_nx = s_mode ? STEP_INS : STEP_CYC;
                end
            end
            RUN: begin
                if (bp_cond) begin
                    fsm_nx = HALT;
                    hit    = 1'b1;
                end else if (!s_cont) begin
                    fsm_nx = HALT;
                end
            end
            STEP_CYC: fsm_nx = HALT;
            STEP_INS: begin
                if (bp_cond) begin
                    fsm_nx = HALT;
                    hit    = 1'b1;
                end else if (cont_rise) begin
                    fsm_nx = RUN;
                end else if (ins_done) begin
                    fsm_nx = HALT;
                end
            end
            default: fsm_nx = HALT;
        endcase
    end

    // The enable is decoded from the registered FSM and masked by the CPU's own
    // registered state/PC, so the CPU stops exactly on the fetch being checked.
    always_comb begin
        cpu_en = 1'b0;
        case (fsm)
            RUN:      cpu_en = ~bp_cond;
            STEP_CYC: cpu_en = 1'b1;
            STEP_INS: cpu_en = ~bp_cond & ~ins_done;
            default:  cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk_500 or negedge rst_n) begin
        if (!rst_n) begin
            fsm      <= HALT;
            bp_hit   <= 1'b0;
            bp_armed <= 1'b0;
        end else begin
            fsm <= fsm_nx;
            if ((fsm == HALT) && (fsm_nx != HALT)) begin
                bp_hit   <= 1'b0;
                bp_armed <= 1'b0;
            end else if (hit) begin
                bp_hit   <= 1'b1;
                bp_armed <= 1'b0;
            end else if (cpu_en) begin
                bp_armed <= 1'b1;
            end
        end
    end

    assign halted = (fsm == HALT);

    logic [REP_W-1:0] rep_cnt;
    logic             repeating;
    logic [7:0]       addr_step;

    assign addr_step = inc_deb ? (ddu_raddr + 8'd1) : (ddu_raddr - 8'd1);

    // Repeat timing: REPEAT_DELAY cycles of silence after the press, then one
    // step at the end of every REPEAT_RATE window.
    always_ff @(posedge clk_500 or negedge rst_n) begin
        if (!rst_n) begin
            ddu_raddr <= '0;
            rep_cnt   <= '0;
            repeating <= 1'b0;
        end else if (inc_deb == dec_deb) begin
            rep_cnt   <= '0;
            repeating <= 1'b0;
        end else if (inc_rise || dec_rise) begin
            ddu_raddr <= addr_step;
            rep_cnt   <= '0;
            repeating <= 1'b0;
        end else if (!repeating) begin
            if (rep_cnt == REP_W'(REPEAT_DELAY - 1)) begin
                repeating <= 1'b1;
                rep_cnt   <= '0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end else if (rep_cnt == REP_W'(REPEAT_RATE - 1)) begin
            ddu_raddr <= addr_step;
            rep_cnt   <= '0;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ddu_run_ctrl.sv
// Scoreboard bench for ddu_run_ctrl: expected enable bursts and address values are
// queued with the stimulus; a monitor pops them as halts and address changes occur.
module tb_ddu_run_ctrl;

    logic        clk_500    = 1'b0;
    logic        rst_n      = 1'b0;
    logic        cont       = 1'b0;
    logic        step       = 1'b0;
    logic        instr_mode = 1'b0;
    logic        inc        = 1'b0;
    logic        dec        = 1'b0;
    logic        bp_en      = 1'b0;
    logic [31:0] bp_addr    = '0;
    logic [31:0] pc_addr;
    logic [3:0]  state;
    logic        cpu_en;
    logic [7:0]  ddu_raddr;
    logic        halted;
    logic        bp_hit;

    ddu_run_ctrl #(
        .DEB_CYCLES  (10),
        .REPEAT_DELAY(250),
        .REPEAT_RATE (50),
        .FETCH_STATE (4'd0)
    ) dut (
        .clk_500   (clk_500),
        .rst_n     (rst_n),
        .cont      (cont),
        .step      (step),
        .instr_mode(instr_mode),
        .inc       (inc),
        .dec       (dec),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc_addr   (pc_addr),
        .state     (state),
        .cpu_en    (cpu_en),
        .ddu_raddr (ddu_raddr),
        .halted    (halted),
        .bp_hit    (bp_hit)
    );

    always #5 clk_500 = ~clk_500;

    // CPU model: states 0 -> 1 -> 2 -> 0, PC advances by 4 when leaving state 2
    always @(posedge clk_500 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= 4'd0;
            pc_addr <= 32'd0;
        end else if (cpu_en) begin
            if (state == 4'd2) begin
                state   <= 4'd0;
                pc_addr <= pc_addr + 32'd4;
            end else begin
                state <= state + 4'd1;
            end
        end
    end

    typedef struct {
        int          len;
        logic        hit;
        logic [3:0]  st;
        logic [31:0] pc;
    } burst_t;

    burst_t     burst_q[$];
    logic [7:0] addr_q[$];
    burst_t     want;
    int         checks    = 0;
    int         errors    = 0;
    int         en_total  = 0;
    int         en_snap   = 0;
    int         burst_len = 0;
    logic       prev_halted = 1'b1;
    logic [7:0] prev_raddr  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_burst(input int len, input logic hit, input logic [3:0] st,
                              input logic [31:0] pc);
        burst_t b;
        b.len = len;
        b.hit = hit;
        b.st  = st;
        b.pc  = pc;
        burst_q.push_back(b);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_500);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 600; i++) begin
            if (burst_q.size() == 0 && addr_q.size() == 0) break;
            @(posedge clk_500);
        end
        chk(name, 32'(burst_q.size() + addr_q.size()), 32'd0);
        tick(1);
    endtask

    always @(negedge clk_500) begin
        if (!rst_n) begin
            prev_halted = 1'b1;
            burst_len   = 0;
            prev_raddr  = ddu_raddr;
        end else begin
            if (!halted && prev_halted) burst_len = 0;
            if (cpu_en) begin
                burst_len++;
                en_total++;
            end
            if (halted && !prev_halted) begin
                if (burst_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_halt: got halt after %0d enables, expected no burst", burst_len);
                end else begin
                    want = burst_q.pop_front();
                    chk("burst_len", 32'(burst_len), 32'(want.len));
                    chk("bp_hit", 32'(bp_hit), 32'(want.hit));
                    chk("halt_state", 32'(state), 32'(want.st));
                    chk("halt_pc", pc_addr, want.pc);
                end
            end
            prev_halted = halted;
            if (ddu_raddr != prev_raddr) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_raddr: got 0x%0h, expected no change from 0x%0h", ddu_raddr, prev_raddr);
                end else begin
                    chk("ddu_raddr", 32'(ddu_raddr), 32'(addr_q.pop_front()));
                end
            end
            prev_raddr = ddu_raddr;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        tick(4);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_raddr", 32'(ddu_raddr), 32'd0);
        chk("rst_bp_hit", 32'(bp_hit), 32'd0);
        rst_n = 1'b1;
        tick(5);

        // Move the address, start a run, then reset in the middle of it
        addr_q.push_back(8'd255);
        dec = 1'b1; tick(20); dec = 1'b0; tick(30);
        cont = 1'b1;
        tick(15);
        chk("run_cpu_en", 32'(cpu_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("midrun_rst_halted", 32'(halted), 32'd1);
        chk("midrun_rst_raddr", 32'(ddu_raddr), 32'd0);
        chk("midrun_rst_bp_hit", 32'(bp_hit), 32'd0);
        tick(3);
        rst_n = 1'b1;
        en_snap = en_total;
        tick(30);
        chk("cont_held_after_rst_halted", 32'(halted), 32'd1);
        chk("cont_held_after_rst_no_en", 32'(en_total), 32'(en_snap));

        // Single-cycle step with a bouncing button
        cont = 1'b0;
        instr_mode = 1'b0;
        tick(5);
        push_burst(1, 1'b0, 4'd1, 32'h0);
        step = 1'b1; tick(1); step = 1'b0; tick(1);
        step = 1'b1; tick(2); step = 1'b0; tick(1);
        step = 1'b1; tick(1); step = 1'b0; tick(2);
        step = 1'b1; tick(20); step = 1'b0; tick(30);
        drain("drain_step_cyc");

        // Instruction steps: from state 1 (two enables), then from state 0 (three)
        instr_mode = 1'b1;
        tick(5);
        push_burst(2, 1'b0, 4'd0, 32'h4);
        step = 1'b1; tick(20); step = 1'b0; tick(30);
        push_burst(3, 1'b0, 4'd0, 32'h8);
        step = 1'b1; tick(20); step = 1'b0; tick(30);
        drain("drain_step_ins");

        // Breakpoint at 0x10 reached from pc 0x8 state 0
        bp_addr = 32'h10;
        bp_en = 1'b1;
        instr_mode = 1'b0;
        tick(5);
        push_burst(6, 1'b1, 4'd0, 32'h10);
        cont = 1'b1;
        tick(40);
        drain("drain_bp_run");
        en_snap = en_total;
        tick(30);
        chk("bp_cont_held_halted", 32'(halted), 32'd1);
        chk("bp_cont_held_no_en", 32'(en_total), 32'(en_snap));

        // Instruction step off the breakpoint must not re-halt on its first cycle
        instr_mode = 1'b1;
        tick(5);
        push_burst(3, 1'b0, 4'd0, 32'h14);
        step = 1'b1; tick(20); step = 1'b0; tick(30);
        drain("drain_bp_resume");

        // A fresh cont edge resumes; next breakpoint at 0x1C
        bp_addr = 32'h1C;
        cont = 1'b0;
        tick(5);
        push_burst(6, 1'b1, 4'd0, 32'h1C);
        cont = 1'b1;
        tick(30);
        drain("drain_cont_toggle");

        // Run ended by cont: 17 cycles high gives 17 enables
        bp_en = 1'b0;
        cont = 1'b0;
        tick(5);
        push_burst(17, 1'b0, 4'd2, 32'h30);
        cont = 1'b1;
        tick(17);
        cont = 1'b0;
        tick(10);
        drain("drain_cont_stop");

        // Address: 0 -> 255 -> 254, then held inc 254 -> 255 -> 0 -> 1
        addr_q.push_back(8'd255);
        dec = 1'b1; tick(20); dec = 1'b0; tick(30);
        addr_q.push_back(8'd254);
        dec = 1'b1; tick(20); dec = 1'b0; tick(30);
        addr_q.push_back(8'd255);
        addr_q.push_back(8'd0);
        addr_q.push_back(8'd1);
        inc = 1'b1; tick(370); inc = 1'b0; tick(40);
        drain("drain_autorepeat");

        inc = 1'b1;
        dec = 1'b1;
        tick(400);
        inc = 1'b0;
        dec = 1'b0;
        tick(40);
        chk("both_held_raddr", 32'(ddu_raddr), 32'd1);
        chk("final_halted", 32'(halted), 32'd1);
        drain("drain_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
